coil_input_debounce: RTL and testbench
======================================

// Module: coil_input_debounce
// PURPOSE
//  Input conditioner directly upstream of the CPU's 4-bit PIO input port.
//  Synchronises raw coil-driver status lines (fault/ready/interlock), debounces each bit,
//  and drives the clean levels onto the PIO in_port. Also offers an Avalon-MM slave
//  with a sticky edge-capture register, an IRQ mask and an interrupt output, so the CPU
//  never has to poll for short-lived transitions.
// PARAMETERS
//  WIDTH            4     number of input lines
//  DEBOUNCE_CYCLES  5000  consecutive clk cycles a changed level must persist (>=1); 100us @50MHz
//  CNT_W (local)    $clog2(DEBOUNCE_CYCLES+1)  per-bit counter width
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  raw_in     in   WIDTH  asynchronous raw status lines from the coil driver
//  clean_out  out  WIDTH  debounced levels; connects to the PIO in_port
//  chipselect in   1      Avalon slave select
//  address    in   2      Avalon word address
//  write      in   1      Avalon write strobe (effective only with chipselect=1)
//  writedata  in   32     Avalon write data
//  readdata   out  32     Avalon read data, registered, zero-extended
//  irq        out  1      level interrupt, registered
// BEHAVIOUR
//  Reset: sync stages, stable levels, counters, mask, edge_cap, readdata and irq all 0.
//   The async assert clears everything at once. Release is synchronous to clk.
//  Sync: 2-FF synchroniser per bit (s1 <- raw_in, s2 <- s1). s2 is the debouncer input.
//  Debounce (per bit i, independent):
//   - s2==stable: cnt <= 0.
//   - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
//   - otherwise: cnt <= cnt+1.
//   - clean_out = stable (registered). A change held at raw_in appears on clean_out on the
//     (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples it as edge 1.
//   - A pulse seen at s2 for fewer than DEBOUNCE_CYCLES cycles is rejected and cnt returns to 0.
//   - DEBOUNCE_CYCLES=1 gives a pure 2-FF synchroniser with 3-edge latency.
//   - cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
//  Edge capture: edge_cap[i] <= 1 in the cycle after stable[i] changes (either direction).
//   - Sticky until cleared by writing 1 to that bit at address 3.
//   - If a set and a clear hit the same bit in the same cycle, the set wins.
//   - A level held at 1 through reset produces a captured edge once it debounces. This is intended.
//  Register map (32-bit words, bits above WIDTH read 0, writes to them ignored):
//   - addr0 LEVEL: RO, stable[WIDTH-1:0]. Writes are ignored.
//   - addr1 MASK: RW, irq_mask.
//   - addr2: reserved. Reads 0, writes ignored.
//   - addr3 EDGE: read edge_cap; write-1-to-clear.
//  Writes take effect on the clk edge where chipselect&write=1.
//  readdata <= mux(address) on every clk edge, independent of chipselect, so read latency
//   is 1 cycle. It reflects register state before any write in that same cycle.
//  irq <= |(edge_cap & irq_mask), registered. It rises 1 cycle after edge_cap or mask
//   makes the term true and falls 1 cycle after it is cleared.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  1. Reset, raw_in=4'h0: clean_out=0, readdata=0, irq=0. Hold 20 cycles: nothing changes.
//  2. Glitch: raw_in[0]=1 for 3 edges, then 0 -> clean_out[0] stays 0, edge_cap stays 0, irq stays 0.
//  3. raw_in[2]=1 held -> clean_out=4'h4 exactly at edge 6 (first sampling edge = 1);
//     edge_cap reads 4'h4 at addr3; irq stays 0 (mask 0).
//  4. Write addr1=0x4 -> irq=1 one cycle later. Then write addr3=0x4 -> edge_cap=0, irq=0 one cycle later.
//     Repeat with the clear in the same cycle as a new bit-2 edge -> edge_cap[2] remains 1.
//  5. address=0 then 2 on consecutive cycles -> readdata=0x00000004 then 0x00000000,
//     each one cycle after its address.
//  6. raw_in[1]=1; pull reset_n low when cnt[1]=2 -> all state 0 immediately.
//     After release, clean_out[1] rises 6 edges later (count restarted from 0).

Source files
------------

// File: rtl/coil_input_debounce.sv
// ============================================================================
// coil_input_debounce : sync + per-bit debounce of coil status lines, Avalon
//                       edge-capture/mask registers and a level IRQ.
// Revision 1.0
// ============================================================================
`default_nettype none

module coil_input_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [31:0]      readdata_d;
  logic             irq_d;
  logic             wr_en;
  logic [WIDTH-1:0] clr_bits;

  // Counter only advances while the synchronised level disagrees with the stable one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    wr_en      = chipselect & write;
    clr_bits   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~clr_bits) | changed_q;
    mask_d     = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
    irq_d      = |(edge_cap_q & mask_q);
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd1:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      changed_q  <= '0;
      edge_cap_q <= '0;
      mask_q     <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= raw_in;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      changed_q  <= stable_d ^ stable_q;
      edge_cap_q <= edge_cap_d;
      mask_q     <= mask_d;
      readdata   <= readdata_d;
      irq        <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign clean_out = stable_q;

endmodule

`default_nettype wire

// File: tb/tb_coil_input_debounce.sv
// ============================================================================
// tb_coil_input_debounce : directed + random checks against a window model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_coil_input_debounce;

  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  raw_in;
  logic [W-1:0]  clean_out;
  logic          chipselect;
  logic [1:0]    address;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad   = 0;

  coil_input_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the last DC synchronised samples all
  // disagree with the current accepted level.
  logic [W-1:0]  m_s1, m_s2, m_stable, m_chg, m_cap, m_mask;
  logic [W-1:0]  m_hist [DC];
  logic [31:0]   m_rd;
  logic          m_irq;

  function automatic logic [W-1:0] settle_bits();
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      logic all_diff;
      all_diff = (m_s2[b] != m_stable[b]);
      for (int k = 0; k < DC - 1; k++)
        if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      r[b] = all_diff;
    end
    return r;
  endfunction

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_stable};
      2'd1:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_chg <= '0;
      m_cap <= '0; m_mask <= '0; m_rd <= '0; m_irq <= 1'b0;
      for (int k = 0; k < DC; k++) m_hist[k] <= '0;
    end else begin
      m_s1     <= raw_in;
      m_s2     <= m_s1;
      m_hist[0] <= m_s2;
      for (int k = 1; k < DC; k++) m_hist[k] <= m_hist[k-1];
      m_stable <= m_stable ^ settle_bits();
      m_chg    <= settle_bits();
      m_cap    <= (m_cap & ~((chipselect && write && address == 2'd3) ? writedata[W-1:0] : 4'd0)) | m_chg;
      if (chipselect && write && address == 2'd1) m_mask <= writedata[W-1:0];
      m_irq    <= |(m_cap & m_mask);
      m_rd     <= reg_view(address);
    end
  end

  always @(negedge clk) begin
    check("clean_out", {28'd0, clean_out}, {28'd0, m_stable});
    check("readdata", readdata, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(posedge clk); @(posedge clk); #1;
    check(nm, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; raw_in = '0; chipselect = 1'b0; write = 1'b0;
    address = 2'd0; writedata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    check("t1_clean", {28'd0, clean_out}, 32'd0);
    check("t1_rd", readdata, 32'd0);
    check("t1_irq", {31'd0, irq}, 32'd0);

    // 2: three-edge glitch on bit 0 is rejected
    raw_in = 4'h1;
    repeat (3) @(negedge clk);
    raw_in = 4'h0;
    repeat (8) @(negedge clk);
    check("t2_clean", {28'd0, clean_out}, 32'd0);
    read_check("t2_edge", 2'd3, 32'd0);
    check("t2_irq", {31'd0, irq}, 32'd0);

    // 3: bit 2 held, appears exactly at edge 6
    @(negedge clk);
    raw_in = 4'h4;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 5) check("t3_edge5", {28'd0, clean_out}, 32'd0);
      if (e == 6) check("t3_edge6", {28'd0, clean_out}, 32'd4);
    end
    read_check("t3_cap", 2'd3, 32'd4);
    check("t3_irq", {31'd0, irq}, 32'd0);

    // 4: mask -> irq, clear -> irq drops, clear colliding with new edge
    bus_write(2'd1, 32'h4);
    @(posedge clk); #1;
    check("t4_irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h4);
    @(posedge clk); #1;
    check("t4_irq_clr", {31'd0, irq}, 32'd0);
    read_check("t4_cap_clr", 2'd3, 32'd0);
    @(negedge clk);
    raw_in = 4'h0;
    repeat (6) @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h4;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    read_check("t4_set_wins", 2'd3, 32'd4);
    check("t4_irq_again", {31'd0, irq}, 32'd1);

    // 5: one-cycle read latency
    @(negedge clk);
    raw_in = 4'h4;
    repeat (10) @(negedge clk);
    address = 2'd0;
    @(posedge clk); #1;
    check("t5_level", readdata, 32'h4);
    @(negedge clk);
    address = 2'd2;
    @(posedge clk); #1;
    check("t5_rsvd", readdata, 32'h0);

    // 6: reset mid-count restarts the debounce
    @(negedge clk);
    raw_in = 4'h6;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_clean", {28'd0, clean_out}, 32'd0);
    check("t6_rst_rd", readdata, 32'd0);
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 5) check("t6_edge5", {28'd0, clean_out}, 32'd0);
      if (e == 6) check("t6_edge6", {28'd0, clean_out}, 32'd6);
    end

    // random traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) raw_in = 4'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write      = ($urandom_range(0, 1) == 0);
      address    = 2'($urandom);
      writedata  = $urandom;
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
